// File: rtl/fifo_uart_tx.sv
// Byte-FIFO read-side consumer serialising each byte as an 8N1 frame (8E1 when FIFO_TX_PARITY_EN is defined).
// Latency: rd 1 cycle after enable && !empty in IDLE, start bit 3 cycles after; frame-to-frame period is frame + 2 cycles.
// Backpressure: pops only when enable && !empty in IDLE or in the last stop cycle; enable low lets the current frame finish.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout,
    input  logic              enable,
    output logic              rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_START,
        S_DATA,
`ifdef FIFO_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  sreg;
    logic [BAUD_W-1:0]  baud;
    logic [BIT_W-1:0]   bit_cnt;
    logic               start_ok;
    logic               baud_end;
`ifdef FIFO_TX_PARITY_EN
    logic               par;
`endif

    assign start_ok = enable && !empty;
    assign baud_end = (baud == BAUD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            rd         <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sreg       <= '0;
            baud       <= '0;
            bit_cnt    <= '0;
`ifdef FIFO_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            rd         <= 1'b0;
            frame_done <= 1'b0;
            baud       <= baud + 1'b1;
            case (state)
                S_IDLE: begin
                    tx   <= 1'b1;
                    baud <= '0;
                    if (start_ok) begin
                        state <= S_FETCH;
                        rd    <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                    baud  <= '0;
                end
                // FIFO data is valid here, one cycle after the pop strobe
                S_LATCH: begin
                    sreg    <= dout;
`ifdef FIFO_TX_PARITY_EN
                    par     <= ^dout;
`endif
                    state   <= S_START;
                    tx      <= 1'b0;
                    baud    <= '0;
                    bit_cnt <= '0;
                end
                S_START: begin
                    if (baud_end) begin
                        state <= S_DATA;
                        baud  <= '0;
                        tx    <= sreg[0];
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud <= '0;
                        sreg <= sreg >> 1;
                        if (bit_cnt == BIT_LAST) begin
`ifdef FIFO_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= par;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= sreg[1];
                        end
                    end
                end
`ifdef FIFO_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        state <= S_STOP;
                        baud  <= '0;
                        tx    <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // registered pulse: raise it entering the final stop cycle
                    if (baud == BAUD_PRE) frame_done <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (start_ok) begin
                            state <= S_FETCH;
                            rd    <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    baud  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: behavioural FIFO, frame capture and table of hand-computed frames.
module tb_fifo_uart_tx;

    localparam int C  = 4;
`ifdef FIFO_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clock;
    logic       reset;
    logic       empty;
    logic [7:0] dout;
    logic       enable;
    logic       rd;
    logic       tx;
    logic       busy;
    logic       frame_done;

    fifo_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .empty      (empty),
        .dout       (dout),
        .enable     (enable),
        .rd         (rd),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural FIFO: bench pushes, DUT pops
    logic [7:0] mem [0:63];
    int wp = 0;
    int rp = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int underflow = 0;
    int rd_cyc[$];

    assign empty = (wp == rp);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (rd === 1'b1) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc.push_back(cyc);
            if (rp == wp) underflow <= underflow + 1;
            else begin
                dout <= mem[rp];
                rp   <= rp + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp = wp + 1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // tx order, start bit first (MSB) down to stop bit
        logic       par;
    } vec_t;
    vec_t vec [8];

    function automatic logic [10:0] exp_frame(input vec_t e);
`ifdef FIFO_TX_PARITY_EN
        return {e.frame[9:1], e.par, 1'b1};
`else
        return {1'b0, e.frame};
`endif
    endfunction

    task automatic wait_tx_fall(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (tx !== 1'b0 && n < 100);
    endtask

    // called at the negedge of the first start-bit cycle
    task automatic capture(input int drop_at, output logic [10:0] bits,
                           output int done_at, output int done_n, output int glitch);
        bits = '0; done_at = -1; done_n = 0; glitch = 0;
        for (int i = 0; i < NB*C; i++) begin
            if (i > 0) @(negedge clock);
            if (i == drop_at) enable = 1'b0;
            if (i % C == 0) bits[NB-1-i/C] = tx;
            else if (tx !== bits[NB-1-i/C]) glitch++;
            if (frame_done === 1'b1) begin
                done_n++;
                done_at = i;
            end
        end
    endtask

    task automatic check_frame(input string name, input vec_t e, input int drop_at);
        logic [10:0] bits;
        int done_at, done_n, glitch;
        capture(drop_at, bits, done_at, done_n, glitch);
        chk({name, " bits"}, 32'(bits), 32'(exp_frame(e)));
        chk({name, " done_at"}, done_at, NB*C-1);
        chk({name, " done_n"}, done_n, 1);
        chk({name, " glitch"}, glitch, 0);
    endtask

    task automatic idle_watch(input int n, output int bad);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (tx !== 1'b1 || rd !== 1'b0 || busy !== 1'b0) bad++;
        end
    endtask

    initial begin
        int n, bad, r0, base;
        vec[0] = '{8'h68, 10'b0_00010110_1, 1'b1};
        vec[1] = '{8'h6F, 10'b0_11110110_1, 1'b0};
        vec[2] = '{8'h6C, 10'b0_00110110_1, 1'b0};
        vec[3] = '{8'h61, 10'b0_10000110_1, 1'b1};
        vec[4] = '{8'h00, 10'b0_00000000_1, 1'b0};
        vec[5] = '{8'hFF, 10'b0_11111111_1, 1'b0};
        vec[6] = '{8'hA5, 10'b0_10100101_1, 1'b0};
        vec[7] = '{8'h03, 10'b0_11000000_1, 1'b0};

        // reset held with data waiting
        reset = 1'b1;
        enable = 1'b1;
        push(vec[0].data);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk($sformatf("reset_outs%0d", i), {29'd0, tx, rd, busy}, 32'b100);
        end
        reset = 1'b0;
        @(negedge clock);
        chk("first_rd", {30'd0, rd, busy}, 32'b11);
        @(negedge clock);
        chk("latch_cycle", {30'd0, rd, tx}, 32'b01);
        wait_tx_fall(n);
        chk("tx_fall_cycle", n, 1);
        check_frame("h_frame", vec[0], -1);
        @(negedge clock);
        chk("h_idle", {30'd0, busy, tx}, 32'b01);
        chk("h_rd_cnt", rd_cnt, 1);

        // single frames from the table
        for (int i = 4; i < 8; i++) begin
            r0 = rd_cnt;
            push(vec[i].data);
            wait_tx_fall(n);
            chk($sformatf("v%0d_latency", i), n, 3);
            check_frame($sformatf("v%0d", i), vec[i], -1);
            @(negedge clock);
            chk($sformatf("v%0d_idle", i), {30'd0, busy, tx}, 32'b01);
            chk($sformatf("v%0d_rd_cnt", i), rd_cnt - r0, 1);
        end

        // back-to-back "ola"
        enable = 1'b0;
        r0 = rd_cnt;
        base = rd_cyc.size();
        push(vec[1].data);
        push(vec[2].data);
        push(vec[3].data);
        @(negedge clock);
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wait_tx_fall(n);
            chk($sformatf("ola%0d_gap", i), n, 3);
            check_frame($sformatf("ola%0d", i), vec[i], -1);
        end
        idle_watch(20, bad);
        chk("ola_idle", bad, 0);
        chk("ola_rd_cnt", rd_cnt - r0, 3);
        if (rd_cyc.size() >= base + 3) begin
            chk("ola_rd_space1", rd_cyc[base+1] - rd_cyc[base], NB*C+2);
            chk("ola_rd_space2", rd_cyc[base+2] - rd_cyc[base+1], NB*C+2);
        end else chk("ola_rd_recorded", rd_cyc.size() - base, 3);

        // flow control
        enable = 1'b0;
        r0 = rd_cnt;
        push(vec[6].data);
        push(vec[4].data);
        idle_watch(20, bad);
        chk("en_off_idle", bad, 0);
        enable = 1'b1;
        wait_tx_fall(n);
        chk("en_on_latency", n, 3);
        check_frame("en_drop", vec[6], 2*C+1);
        idle_watch(30, bad);
        chk("en_drop_idle", bad, 0);
        chk("en_rd_cnt", rd_cnt - r0, 1);

        // reset during data bit 4 of the 0x00 frame, then 0xFF follows
        r0 = rd_cnt;
        push(vec[5].data);
        enable = 1'b1;
        wait_tx_fall(n);
        chk("abort_latency", n, 3);
        for (int i = 0; i < 4*1 + 4*C + 1; i++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_outs", {30'd0, tx, busy}, 32'b10);
        reset = 1'b0;
        wait_tx_fall(n);
        chk("post_abort_latency", n, 3);
        check_frame("post_abort", vec[5], -1);
        idle_watch(20, bad);
        chk("post_abort_idle", bad, 0);
        chk("abort_rd_cnt", rd_cnt - r0, 2);
        chk("fifo_empty", {31'd0, empty}, 1);
        chk("underflow", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the byte FIFO: pops bytes when the FIFO is non-empty and serialises each as an asynchronous 8N1 frame on a single TX line. The FIFO's `wr`/`din` side is filled by the upstream producer; this block owns the FIFO `rd` strobe and consumes its data output. It is the serial link driver toward the host or cube controller.

## Interface
- `CLKS_PER_BIT`, default 16, clock cycles per serial bit; legal range ≥ 2.
- `DATA_W`, default 8, byte width; must match the FIFO data width.

Ports:
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `empty` in 1: FIFO empty flag.
- `dout` in DATA_W: FIFO read data; valid the cycle after `rd` is high.
- `enable` in 1: permits starting new frames.
- `rd` out 1: FIFO pop strobe; registered; high for exactly one cycle per byte.
- `tx` out 1: serial line; idle high.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- FSM states: IDLE, FETCH, LATCH, START, DATA, [PARITY], STOP.
- IDLE: `tx`=1. If `enable` && !`empty`, go to FETCH.
- FETCH: exactly 1 cycle; `rd`=1; go to LATCH.
- LATCH: exactly 1 cycle; shift register <= `dout` at the end of the cycle; go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: DATA_W bits, LSB first, CLKS_PER_BIT cycles each. Shift right at each bit boundary. A 3-bit bit counter runs 0..DATA_W-1.
- STOP: `tx`=1 for CLKS_PER_BIT cycles; `frame_done`=1 in the final cycle.
  - Next state is FETCH if `enable` && !`empty` at that cycle, else IDLE.
- Baud counter width is clog2(CLKS_PER_BIT). It reloads to 0 on every state entry and wraps at CLKS_PER_BIT-1.
- `enable` dropping mid-frame does not abort; the current frame completes, then the FSM goes to IDLE.
- `empty` is sampled only in IDLE and in the last STOP cycle. `rd` is never asserted while `empty`=1, so the FIFO cannot underflow.
- `reset` mid-frame aborts immediately. A byte already popped is discarded, not replayed.

## Timing
- Reset values: state IDLE, `tx`=1, `rd`=0, `busy`=0, `frame_done`=0; shift register and counters 0.
- Latency from `empty` low in IDLE (cycle 0):
  - `rd` high in cycle 1;
  - `busy` high from cycle 1;
  - `tx` falls in cycle 3.
- Frame length: (DATA_W+2)·CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
- Back-to-back period: frame length + 2 cycles (FETCH + LATCH). `tx` stays high during those 2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `FIFO_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP.
  - `tx` = even parity (XOR of the data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 8E1.
- Undefined: PARITY state and its logic are absent; frame is 8N1.

## Test plan
Unless noted: CLKS_PER_BIT=4, parity undefined.
- Reset behaviour: hold `reset`=1 for 3 cycles with `empty`=0 → `tx`=1, `rd`=0, `busy`=0 throughout. First `rd` occurs in the 1st cycle after `reset` falls.
- Single byte 0x68 ("h"):
  - `rd` pulses exactly once;
  - `tx` bit sequence, 4 cycles each: 0, 0,0,0,1,0,1,1,0, 1;
  - `frame_done` pulses at cycle 3+40-1;
  - then IDLE with `busy`=0.
- Back-to-back "ola" with FIFO pre-loaded:
  - 3 `rd` pulses spaced 42 cycles apart;
  - decoded bytes 0x6F, 0x6C, 0x61;
  - `tx` high for exactly 2 cycles between each stop bit and the next start bit;
  - no `rd` after `empty` rises.
- Flow control: `enable`=0 with `empty`=0 → no `rd`, `tx`=1. Drop `enable` mid-DATA → current frame completes, then no further `rd`.
- Reset mid-frame: assert `reset` during DATA bit 4 → next cycle `tx`=1, `busy`=0. After release, the next FIFO byte is sent and the aborted byte is not resent.
- With `FIFO_TX_PARITY_EN`: byte 0x68 → parity bit 1 before stop; byte 0x03 → parity bit 0; frame length 44 cycles.
